// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: valid/ready request with operands,
// valid/ready response with result halves, flags and busy status.
interface alu_multicycle_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUControl;
  logic [N-1:0] ALUInA;
  logic [N-1:0] ALUInB;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] ALUResult;
  logic [N-1:0] ALUResultHi;
  logic         ALUZero;
  logic         ALUOverflow;
  logic         busy;

  modport master (
    output in_valid, ALUControl, ALUInA, ALUInB, out_ready,
    input  in_ready, out_valid, ALUResult, ALUResultHi, ALUZero, ALUOverflow, busy
  );

  modport slave (
    input  in_valid, ALUControl, ALUInA, ALUInB, out_ready,
    output in_ready, out_valid, ALUResult, ALUResultHi, ALUZero, ALUOverflow, busy
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, N-step shift-add MUL and, when
// ALU_MULTICYCLE_DIV_EN is defined, N-step restoring DIV; results held until taken.
module alu_multicycle #(parameter int N = 32) (
  input  logic            clk,
  input  logic            reset,
  alu_multicycle_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2, OP_XOR = 4'd3,
                         OP_NOR = 4'd4, OP_SUB = 4'd6, OP_SLT = 4'd7, OP_MUL = 4'd8;
`ifdef ALU_MULTICYCLE_DIV_EN
  localparam logic [3:0] OP_DIV = 4'd9;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [3:0]   op;
  logic [N-1:0] a, b, sum, diff;
  logic         accept, start_iter, last_iter;
  logic [CW-1:0] cnt;
  logic [N-1:0] acc_hi, acc_lo, mcand, step_hi, step_lo;
  logic [N-1:0] sc_lo, sc_hi;
  logic         sc_ovf;
  logic [N-1:0] res_lo, res_hi;
  logic         res_zero, res_ovf;
  logic [N:0]   mul_sum;

  assign op        = bus.ALUControl;
  assign a         = bus.ALUInA;
  assign b         = bus.ALUInB;
  assign sum       = a + b;
  assign diff      = a - b;
  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_iter = (cnt == CW'(N - 1));

  // {acc_hi, acc_lo} is the product register; acc_lo starts as the multiplier
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(N+1){1'b0}});

`ifdef ALU_MULTICYCLE_DIV_EN
  logic       is_div, div_ge;
  logic [N:0] div_rem, div_diff;

  // Divide by zero resolves in one cycle, so only B!=0 enters the iterative path
  assign start_iter = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
  assign div_rem    = {acc_hi, acc_lo[N-1]};
  assign div_diff   = div_rem - {1'b0, mcand};
  assign div_ge     = (div_rem >= {1'b0, mcand});

  always_comb begin
    step_hi = mul_sum[N:1];
    step_lo = {mul_sum[0], acc_lo[N-1:1]};
    if (is_div) begin
      step_hi = div_ge ? div_diff[N-1:0] : div_rem[N-1:0];
      step_lo = {acc_lo[N-2:0], div_ge};
    end
  end
`else
  assign start_iter = (op == OP_MUL);
  assign step_hi    = mul_sum[N:1];
  assign step_lo    = {mul_sum[0], acc_lo[N-1:1]};
`endif

  always_comb begin
    sc_lo  = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    case (op)
      OP_AND: sc_lo = a & b;
      OP_OR:  sc_lo = a | b;
      OP_XOR: sc_lo = a ^ b;
      OP_NOR: sc_lo = ~(a | b);
      OP_ADD: begin
        sc_lo  = sum;
        sc_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sc_lo  = diff;
        sc_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_SLT: sc_lo = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
`ifdef ALU_MULTICYCLE_DIV_EN
      OP_DIV: begin
        sc_lo = '1;
        sc_hi = a;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = start_iter ? BUSY : DONE;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state == BUSY);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      res_lo   <= '0;
      res_hi   <= '0;
      res_zero <= 1'b0;
      res_ovf  <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
      is_div   <= 1'b0;
`endif
    end else if (accept) begin
      cnt <= '0;
      if (start_iter) begin
        acc_hi <= '0;
        acc_lo <= a;
        mcand  <= b;
`ifdef ALU_MULTICYCLE_DIV_EN
        is_div <= (op == OP_DIV);
`endif
      end else begin
        res_lo   <= sc_lo;
        res_hi   <= sc_hi;
        res_zero <= (sc_lo == '0);
        res_ovf  <= sc_ovf;
      end
    end else if (state == BUSY) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= last_iter ? '0 : cnt + CW'(1);
      // Result registers only move on the final step so DONE outputs stay put
      if (last_iter) begin
        res_lo   <= step_lo;
        res_hi   <= step_hi;
        res_zero <= (step_lo == '0);
        res_ovf  <= 1'b0;
      end
    end
  end

  assign bus.ALUResult   = res_lo;
  assign bus.ALUResultHi = res_hi;
  assign bus.ALUZero     = res_zero;
  assign bus.ALUOverflow = res_ovf;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed plus random bench for alu_multicycle (N=32) against an arithmetic
// reference model; exercises DIV when ALU_MULTICYCLE_DIV_EN is defined.
module tb_alu_multicycle;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_multicycle_if #(.N(N)) bus();
  alu_multicycle #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands, latency from the op class
  function automatic void model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] lo, output logic [N-1:0] hi,
                                output logic ovf, output int lat);
    longint sa, sb, s, smax, smin;
    logic [2*N-1:0] p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (N - 1)) - 1;
    smin = -(longint'(1) <<< (N - 1));
    lo = '0; hi = '0; ovf = 1'b0; lat = 1;
    case (op)
      4'd0: lo = a & b;
      4'd1: lo = a | b;
      4'd2: begin s = sa + sb; lo = s[N-1:0]; ovf = (s > smax) || (s < smin); end
      4'd3: lo = a ^ b;
      4'd4: lo = ~(a | b);
      4'd6: begin s = sa - sb; lo = s[N-1:0]; ovf = (s > smax) || (s < smin); end
      4'd7: lo = (sa < sb) ? N'(1) : N'(0);
      4'd8: begin
        p  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        lo = p[N-1:0];
        hi = p[2*N-1:N];
        lat = N + 1;
      end
`ifdef ALU_MULTICYCLE_DIV_EN
      4'd9: begin
        if (b == '0) begin
          lo = '1; hi = a;
        end else begin
          lo = a / b; hi = a % b; lat = N + 1;
        end
      end
`endif
      default: ;
    endcase
  endfunction

  // Issue one request, measure latency, check result, hold for 'hold' cycles, then take it
  task automatic run_op(input string tag, input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input int hold);
    logic [N-1:0] exp_lo, exp_hi;
    logic         exp_ovf;
    int           exp_lat, lat, bcnt;
    model(op, a, b, exp_lo, exp_hi, exp_ovf, exp_lat);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
    bus.in_valid   = 1'b1;
    bus.ALUControl = op;
    bus.ALUInA     = a;
    bus.ALUInB     = b;
    bus.out_ready  = 1'b0;
    tick();
    bus.in_valid   = 1'b0;
    bus.ALUControl = 4'($urandom);
    bus.ALUInA     = $urandom;
    bus.ALUInB     = $urandom;
    lat = 1;
    bcnt = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) bcnt++;
      tick();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
    check({tag, ".lo"}, 64'(bus.ALUResult), 64'(exp_lo));
    check({tag, ".hi"}, 64'(bus.ALUResultHi), 64'(exp_hi));
    check({tag, ".ovf"}, 64'(bus.ALUOverflow), 64'(exp_ovf));
    check({tag, ".zero"}, 64'(bus.ALUZero), 64'(exp_lo == '0));
    for (int i = 0; i < hold; i++) begin
      tick();
      bus.ALUInA = $urandom;
      check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'(1));
      check({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'(0));
      check({tag, ".hold_lo"}, 64'(bus.ALUResult), 64'(exp_lo));
      check({tag, ".hold_hi"}, 64'(bus.ALUResultHi), 64'(exp_hi));
    end
    // Offer a new request in the same cycle the result is taken; it must be ignored
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'd2;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, ".after_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, ".after_busy"}, 64'(bus.busy), 64'(0));
    check({tag, ".after_in_ready"}, 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    logic [3:0] ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
    int seen;

    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.ALUControl = '0;
    bus.ALUInA     = '0;
    bus.ALUInB     = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst.out_valid", 64'(bus.out_valid), 64'(0));
    check("rst.busy", 64'(bus.busy), 64'(0));
    check("rst.lo", 64'(bus.ALUResult), 64'(0));
    check("rst.hi", 64'(bus.ALUResultHi), 64'(0));
    check("rst.zero", 64'(bus.ALUZero), 64'(0));
    check("rst.ovf", 64'(bus.ALUOverflow), 64'(0));
    check("rst.in_ready", 64'(bus.in_ready), 64'(1));

    run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op("sub_zero", 4'd6, 32'd5, 32'd5, 0);
    run_op("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("mul_hold", 4'd8, 32'hFFFF_FFFF, 32'h0000_0002, 5);
    run_op("unk5", 4'd5, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("unk15", 4'd15, 32'hFFFF_FFFF, 32'h0000_0001, 0);
`ifdef ALU_MULTICYCLE_DIV_EN
    run_op("div_100_7", 4'd9, 32'd100, 32'd7, 0);
    run_op("div_by0", 4'd9, 32'd9, 32'd0, 0);
`else
    run_op("div_off", 4'd9, 32'd100, 32'd7, 0);
`endif

    // Abort a MUL with reset at its tenth cycle
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'd8;
    bus.ALUInA     = 32'h0001_0003;
    bus.ALUInB     = 32'h0000_0007;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.in_ready", 64'(bus.in_ready), 64'(1));
    check("abort.out_valid", 64'(bus.out_valid), 64'(0));
    check("abort.busy", 64'(bus.busy), 64'(0));
    check("abort.lo", 64'(bus.ALUResult), 64'(0));
    seen = 0;
    for (int i = 0; i < N + 8; i++) begin
      tick();
      if (bus.out_valid || bus.busy) seen++;
    end
    check("abort.no_result", 64'(seen), 64'(0));

    for (int i = 0; i < 30; i++) begin
      logic [N-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 9)) : N'($urandom);
      run_op("rand", ops[$urandom_range(0, 10)], ra, rb, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
